ram_port_arbiter: RTL

Arbitrates the single-port point RAM between two requesters: the host register interface, which loads and reads back points, and the k-means sequencing controller, which streams points during iterations. Owns every RAM control pin (address, data, WEB, OEB, CSB) with registered outputs. Grants the controller exclusive, uninterrupted ownership for a whole iteration burst, and serves host single-word accesses only when the controller does not hold the lock.

---
 rtl/kmeans_pkg.sv | 16 +
 rtl/ram_port_arbiter_wait_timer.sv | 55 +++++
 rtl/ram_port_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/kmeans_pkg.sv
// Shared types for the k-means point-RAM datapath: arbiter states and owner codes.
package kmeans_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOST_CMD,
        HOST_END,
        CORE_OWN,
        CORE_DRAIN
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_HOST = 2'b01;
    localparam logic [1:0] OWNER_CORE = 2'b10;

endpackage

// File: rtl/ram_port_arbiter_wait_timer.sv
// Host wait timer: rejects a host request that has waited WAIT_MAX cycles behind
// core ownership, then masks it until the host lets go of host_req.
module ram_arb_wait_timer #(
    parameter int WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic host_req,
    input  logic core_owned,
    output logic host_mask,
    output logic host_err
);

    localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mask_q, mask_d;
    logic             err_q, err_d;

    always_comb begin
        cnt_d  = cnt_q;
        mask_d = mask_q;
        err_d  = 1'b0;
        if (!host_req) begin
            mask_d = 1'b0;
        end
        if (!host_req || !core_owned || mask_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // one rejection per held request; the mask blocks re-arbitration
            cnt_d  = '0;
            mask_d = 1'b1;
            err_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            mask_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
            err_q  <= err_d;
        end
    end

    assign host_mask = mask_q;
    assign host_err  = err_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Point-RAM arbiter between host register port and k-means controller.
// Optional host wait timeout enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_port_arbiter
    import kmeans_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 50,
    parameter int WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_err,
    input  logic              core_lock,
    input  logic              core_rd,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_lock_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              wr_en_n,
    output logic              output_en_n,
    output logic              chip_select_n,
    output logic [1:0]        owner,
    output logic              busy
);

    arb_state_t        state_q, state_d;
    logic              host_we_q, host_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              web_q, web_d;
    logic              oeb_q, oeb_d;
    logic              csb_q, csb_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic              core_issued_q, core_issued_d;
    logic              core_rvalid_q, core_rvalid_d;
    logic              host_req_eff;
    logic              core_owned;

    assign core_owned = (state_q == CORE_OWN) || (state_q == CORE_DRAIN);

`ifdef RAM_ARB_TIMEOUT_EN
    logic host_mask;

    ram_arb_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .host_req   (host_req),
        .core_owned (core_owned),
        .host_mask  (host_mask),
        .host_err   (host_err)
    );

    assign host_req_eff = host_req & ~host_mask;
`else
    logic unused_wait_max;

    assign unused_wait_max = ^WAIT_MAX;
    assign host_err        = 1'b0;
    assign host_req_eff    = host_req;
`endif

    // RAM pins are computed for the next state so they leave the flops aligned with it
    always_comb begin
        state_d       = state_q;
        host_we_d     = host_we_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        web_d         = 1'b1;
        oeb_d         = 1'b1;
        csb_d         = 1'b1;
        host_rvalid_d = 1'b0;
        core_issued_d = 1'b0;
        core_rvalid_d = core_issued_q;
        case (state_q)
            IDLE: begin
                if (core_lock) begin
                    state_d = CORE_OWN;
                end else if (host_req_eff) begin
                    state_d    = HOST_CMD;
                    host_we_d  = host_we;
                    ram_addr_d = host_addr;
                    csb_d      = 1'b0;
                    if (host_we) begin
                        web_d       = 1'b0;
                        ram_wdata_d = host_wdata;
                    end else begin
                        oeb_d = 1'b0;
                    end
                end
            end
            HOST_CMD: begin
                state_d       = HOST_END;
                host_rvalid_d = ~host_we_q;
            end
            HOST_END: begin
                state_d = IDLE;
            end
            CORE_OWN: begin
                if (!core_lock) begin
                    state_d = CORE_DRAIN;
                end else if (core_rd) begin
                    core_issued_d = 1'b1;
                    csb_d         = 1'b0;
                    oeb_d         = 1'b0;
                    ram_addr_d    = core_addr;
                end
            end
            CORE_DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            host_we_q     <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            web_q         <= 1'b1;
            oeb_q         <= 1'b1;
            csb_q         <= 1'b1;
            host_rvalid_q <= 1'b0;
            core_issued_q <= 1'b0;
            core_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            host_we_q     <= host_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            web_q         <= web_d;
            oeb_q         <= oeb_d;
            csb_q         <= csb_d;
            host_rvalid_q <= host_rvalid_d;
            core_issued_q <= core_issued_d;
            core_rvalid_q <= core_rvalid_d;
        end
    end

    always_comb begin
        owner = OWNER_NONE;
        case (state_q)
            HOST_CMD, HOST_END:   owner = OWNER_HOST;
            CORE_OWN, CORE_DRAIN: owner = OWNER_CORE;
            default:              owner = OWNER_NONE;
        endcase
    end

    assign host_gnt      = (state_q == HOST_CMD);
    assign core_lock_gnt = (state_q == CORE_OWN);
    assign busy          = (state_q != IDLE);
    assign host_rvalid   = host_rvalid_q;
    assign core_rvalid   = core_rvalid_q;
    assign host_rdata    = ram_rdata;
    assign core_rdata    = ram_rdata;
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign wr_en_n       = web_q;
    assign output_en_n   = oeb_q;
    assign chip_select_n = csb_q;

endmodule
